// File: rtl/rs_gf_pkg.sv
// Shared GF(2^M) helpers and types for the Reed-Solomon syndrome engine.
package rs_gf_pkg;

  typedef enum logic [0:0] {ACCUM = 1'b0, HOLD = 1'b1} rs_state_e;

  localparam int DEF_M         = 3;
  localparam int DEF_PRIM_POLY = 11;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  // Multiply sym by alpha^k; with constant k this folds into a fixed XOR network.
  function automatic logic [7:0] gf_mul_alpha_pow(input logic [7:0] sym, input int k,
                                                  input int m, input int prim_poly);
    logic [8:0] v;
    int         n;
    v = {1'b0, sym};
    n = k % ((32'sd1 << m) - 32'sd1);
    for (int i = 0; i < 255; i++) begin
      if (i < n) begin
        v = {v[7:0], 1'b0};
        if ((v & (9'd1 << m)) != 9'd0) v = v ^ 9'(prim_poly);
      end
    end
    return v[7:0];
  endfunction

endpackage

// File: rtl/rs_syn_cell.sv
// One syndrome accumulator: acc <= acc * alpha^EXP ^ sym, or a plain load on the first symbol.
module rs_syn_cell
  import rs_gf_pkg::*;
#(
  parameter int M         = DEF_M,
  parameter int EXP       = 1,
  parameter int PRIM_POLY = DEF_PRIM_POLY
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load_first,
  input  logic         i_acc_en,
  input  logic [M-1:0] i_sym,
  output logic [M-1:0] o_acc_next
);

  logic [M-1:0] r_acc;
  logic [M-1:0] w_mul;
  logic [M-1:0] w_acc_next;

  assign w_mul      = M'(gf_mul_alpha_pow(8'(r_acc), EXP, M, PRIM_POLY));
  assign w_acc_next = i_load_first ? i_sym : (w_mul ^ i_sym);
  assign o_acc_next = w_acc_next;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc <= '0;
    end else if (i_acc_en) begin
      r_acc <= w_acc_next;
    end
  end

endmodule

// File: rtl/rs_syndrome_engine.sv
// Streaming RS syndrome generator: NSYN Horner accumulators, result held until consumed.
module rs_syndrome_engine
  import rs_gf_pkg::*;
#(
  parameter int  M         = DEF_M,
  parameter int  N         = 7,
  parameter int  NSYN      = 2,
  parameter int  FCR       = 1,
  parameter int  PRIM_POLY = DEF_PRIM_POLY,
  localparam int CW        = clog2_f(N + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [M-1:0]      in_sym,
  output logic              syn_valid,
  input  logic              syn_ready,
  output logic [NSYN*M-1:0] syndromes,
  output logic              err_flag,
  output logic [CW-1:0]     sym_count
);

  rs_state_e         r_state;
  rs_state_e         w_state_nxt;
  logic [CW-1:0]     r_sym_count;
  logic [NSYN*M-1:0] r_syndromes;
  logic              r_err_flag;
  logic [NSYN*M-1:0] w_acc_next;
  logic              w_accept;
  logic              w_first;
  logic              w_last;
  logic              w_done;

  // While holding a result, a symbol may only enter on the same cycle the result is taken.
  assign in_ready = (r_state == ACCUM) ? 1'b1 : syn_ready;
  assign w_accept = in_valid & in_ready & ~abort;
  assign w_first  = (r_sym_count == '0);
  assign w_last   = (r_sym_count == CW'(N - 1));
  assign w_done   = w_accept & w_last;

  for (genvar j = 0; j < NSYN; j++) begin : g_cell
    rs_syn_cell #(
      .M         (M),
      .EXP       (FCR + j),
      .PRIM_POLY (PRIM_POLY)
    ) u_cell (
      .clk          (clk),
      .reset        (reset),
      .i_load_first (w_first),
      .i_acc_en     (w_accept),
      .i_sym        (in_sym),
      .o_acc_next   (w_acc_next[j*M +: M])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ACCUM: begin
        if (w_done) w_state_nxt = HOLD;
        else        w_state_nxt = ACCUM;
      end
      HOLD: begin
        if (syn_ready) w_state_nxt = ACCUM;
        else           w_state_nxt = HOLD;
      end
      default: w_state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ACCUM;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sym_count <= '0;
      r_syndromes <= '0;
      r_err_flag  <= 1'b0;
    end else begin
      if (abort) begin
        r_sym_count <= '0;
      end else if (w_accept) begin
        r_sym_count <= w_last ? '0 : r_sym_count + CW'(1);
      end
      if (w_done) begin
        r_syndromes <= w_acc_next;
        r_err_flag  <= |w_acc_next;
      end
    end
  end

  assign syn_valid = (r_state == HOLD);
  assign syndromes = r_syndromes;
  assign err_flag  = r_err_flag;
  assign sym_count = r_sym_count;

endmodule

// File: tb/tb_rs_syndrome_engine.sv
// Randomised bench for rs_syndrome_engine against a direct polynomial-evaluation model.
module tb_rs_syndrome_engine;

  logic        clk = 1'b0;
  logic        reset;
  logic        abort, in_valid, syn_ready;
  logic [2:0]  in_sym;
  logic        in_ready, syn_valid, err_flag;
  logic [5:0]  syndromes;
  logic [2:0]  sym_count;

  logic        b_abort, b_in_valid, b_syn_ready;
  logic [3:0]  b_in_sym;
  logic        b_in_ready, b_syn_valid, b_err_flag;
  logic [15:0] b_syndromes;
  logic [3:0]  b_sym_count;

  int vectors = 0;
  int errors  = 0;
  int cw_q[$];

  int pat[5][7] = '{'{0,0,0,0,0,0,0}, '{0,0,0,0,1,6,3}, '{1,0,0,0,0,0,0},
                    '{0,0,0,0,0,0,5}, '{0,0,0,0,0,1,0}};
  logic [5:0] pat_syn[5] = '{6'o00, 6'o00, 6'o75, 6'o55, 6'o42};

  always #5 clk = ~clk;

  rs_syndrome_engine dut (
    .clk(clk), .reset(reset), .abort(abort), .in_valid(in_valid), .in_ready(in_ready),
    .in_sym(in_sym), .syn_valid(syn_valid), .syn_ready(syn_ready), .syndromes(syndromes),
    .err_flag(err_flag), .sym_count(sym_count)
  );

  rs_syndrome_engine #(.M(4), .N(15), .NSYN(4), .FCR(1), .PRIM_POLY(19)) dut4 (
    .clk(clk), .reset(reset), .abort(b_abort), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_sym(b_in_sym), .syn_valid(b_syn_valid), .syn_ready(b_syn_ready), .syndromes(b_syndromes),
    .err_flag(b_err_flag), .sym_count(b_sym_count)
  );

  // Generic shift-and-add GF(2^m) multiply.
  function automatic int gf_mul(input int a, input int b, input int m, input int poly);
    int r, x;
    r = 0;
    x = a;
    for (int i = 0; i < m; i++) begin
      if (((b >> i) & 1) != 0) r = r ^ x;
      x = x << 1;
      if (((x >> m) & 1) != 0) x = x ^ poly;
    end
    return r;
  endfunction

  function automatic int gf_alpha(input int e, input int m, input int poly);
    int r;
    r = 1;
    for (int i = 0; i < e % ((1 << m) - 1); i++) r = gf_mul(r, 2, m, poly);
    return r;
  endfunction

  // S_j = sum over i of r_i * alpha^((fcr+j)*deg_i), first element of cw_q has the highest degree.
  function automatic int ref_syn(input int j, input int m, input int poly, input int fcr);
    int s, n;
    s = 0;
    n = cw_q.size();
    for (int i = 0; i < n; i++)
      s = s ^ gf_mul(cw_q[i], gf_alpha((fcr + j) * (n - 1 - i), m, poly), m, poly);
    return s;
  endfunction

  function automatic logic [5:0] model_a();
    logic [5:0] r;
    r = '0;
    for (int j = 0; j < 2; j++) r[j*3 +: 3] = 3'(ref_syn(j, 3, 11, 1));
    return r;
  endfunction

  function automatic logic [15:0] model_b();
    logic [15:0] r;
    r = '0;
    for (int j = 0; j < 4; j++) r[j*4 +: 4] = 4'(ref_syn(j, 4, 19, 1));
    return r;
  endfunction

  task automatic random_cw_a(input int single_err);
    cw_q.delete();
    for (int i = 0; i < 7; i++) cw_q.push_back(single_err != 0 ? 0 : int'($urandom_range(7)));
    if (single_err != 0) cw_q[$urandom_range(6)] = int'($urandom_range(7, 1));
  endtask

  task automatic test_reset();
    #3;
    vectors++; if ({in_ready, syn_valid, err_flag} !== 3'b100) begin errors++;
      $display("FAIL reset_flags: got %b want 100", {in_ready, syn_valid, err_flag}); end
    vectors++; if (syndromes !== 6'd0) begin errors++;
      $display("FAIL reset_syn: got %h want 0", syndromes); end
    vectors++; if (sym_count !== 3'd0) begin errors++;
      $display("FAIL reset_count: got %0d want 0", sym_count); end
    vectors++; if ({b_in_ready, b_syn_valid, b_err_flag, b_syndromes, b_sym_count} !== {3'b100, 20'd0}) begin
      errors++; $display("FAIL reset_m4: got %b", {b_in_ready, b_syn_valid, b_err_flag, b_syndromes, b_sym_count}); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_patterns();
    logic [5:0] exp;
    for (int k = 0; k < 9; k++) begin
      if (k < 5) begin
        cw_q.delete();
        for (int i = 0; i < 7; i++) cw_q.push_back(pat[k][i]);
        exp = pat_syn[k];
      end else begin
        random_cw_a(k & 1);
        exp = model_a();
      end
      for (int i = 0; i < 7; i++) begin
        @(negedge clk); in_valid = 1'b1; in_sym = 3'(cw_q[i]); #1;
        vectors++; if (sym_count !== 3'(i)) begin errors++;
          $display("FAIL pat%0d_count: got %0d want %0d", k, sym_count, i); end
        vectors++; if (syn_valid !== 1'b0) begin errors++;
          $display("FAIL pat%0d_early_valid: got %b want 0", k, syn_valid); end
      end
      @(negedge clk); in_valid = 1'b0; in_sym = 3'($urandom); #1;
      vectors++; if (syn_valid !== 1'b1) begin errors++;
        $display("FAIL pat%0d_valid: got %b want 1", k, syn_valid); end
      vectors++; if (syndromes !== exp) begin errors++;
        $display("FAIL pat%0d_syn: got %o want %o", k, syndromes, exp); end
      vectors++; if (err_flag !== (exp != 6'd0)) begin errors++;
        $display("FAIL pat%0d_err: got %b want %b", k, err_flag, exp != 6'd0); end
      syn_ready = 1'b1;
      @(negedge clk); syn_ready = 1'b0; #1;
      vectors++; if (syn_valid !== 1'b0) begin errors++;
        $display("FAIL pat%0d_release: got %b want 0", k, syn_valid); end
    end
  endtask

  task automatic test_back_to_back();
    int cw2[7], cw3[7];
    logic [5:0] exp1, exp2, exp3;
    random_cw_a(0); exp1 = model_a();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); in_valid = 1'b1; in_sym = 3'(cw_q[i]);
    end
    random_cw_a(1); exp2 = model_a();
    for (int i = 0; i < 7; i++) cw2[i] = cw_q[i];
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); in_valid = 1'b1; in_sym = 3'(cw2[0]); #1;
      vectors++; if (in_ready !== 1'b0) begin errors++;
        $display("FAIL bp_ready%0d: got %b want 0", c, in_ready); end
      vectors++; if ({syn_valid, syndromes} !== {1'b1, exp1}) begin errors++;
        $display("FAIL bp_hold%0d: got %b/%o want 1/%o", c, syn_valid, syndromes, exp1); end
    end
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); in_sym = 3'(cw2[i]); syn_ready = (i == 0); #1;
      vectors++; if (in_ready !== 1'b1) begin errors++;
        $display("FAIL bp_cw2_ready%0d: got %b want 1", i, in_ready); end
      vectors++; if (sym_count !== 3'(i)) begin errors++;
        $display("FAIL bp_cw2_count%0d: got %0d want %0d", i, sym_count, i); end
    end
    random_cw_a(0); exp3 = model_a();
    for (int i = 0; i < 7; i++) cw3[i] = cw_q[i];
    @(negedge clk); in_sym = 3'(cw3[0]); syn_ready = 1'b1; #1;
    vectors++; if ({syn_valid, syndromes, in_ready} !== {1'b1, exp2, 1'b1}) begin errors++;
      $display("FAIL b2b_cw2: got %b/%o/%b want 1/%o/1", syn_valid, syndromes, in_ready, exp2); end
    for (int i = 1; i < 7; i++) begin
      @(negedge clk); syn_ready = 1'b0; in_sym = 3'(cw3[i]); #1;
      vectors++; if ({syn_valid, sym_count} !== {1'b0, 3'(i)}) begin errors++;
        $display("FAIL b2b_cw3_count%0d: got %b/%0d want 0/%0d", i, syn_valid, sym_count, i); end
    end
    @(negedge clk); in_valid = 1'b0; #1;
    vectors++; if ({syn_valid, syndromes} !== {1'b1, exp3}) begin errors++;
      $display("FAIL b2b_cw3: got %b/%o want 1/%o", syn_valid, syndromes, exp3); end
    syn_ready = 1'b1;
    @(negedge clk); syn_ready = 1'b0;
  endtask

  task automatic test_gaps_abort();
    logic [5:0] exp;
    cw_q.delete();
    for (int i = 0; i < 7; i++) cw_q.push_back(pat[1][i]);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      while ($urandom_range(99) < 50) begin
        in_valid = 1'b0; in_sym = 3'($urandom); #1;
        vectors++; if (sym_count !== 3'(i)) begin errors++;
          $display("FAIL gap_freeze%0d: got %0d want %0d", i, sym_count, i); end
        @(negedge clk);
      end
      in_valid = 1'b1; in_sym = 3'(cw_q[i]);
    end
    @(negedge clk); in_valid = 1'b0; #1;
    vectors++; if ({syn_valid, syndromes, err_flag} !== {1'b1, 6'd0, 1'b0}) begin errors++;
      $display("FAIL gap_result: got %b/%o/%b want 1/0/0", syn_valid, syndromes, err_flag); end
    syn_ready = 1'b1;
    @(negedge clk); syn_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); in_valid = 1'b1; in_sym = 3'($urandom_range(7, 1));
    end
    @(negedge clk); abort = 1'b1; in_sym = 3'($urandom_range(7, 1));
    @(negedge clk); abort = 1'b0; in_valid = 1'b0; #1;
    vectors++; if (sym_count !== 3'd0) begin errors++;
      $display("FAIL abort_count: got %0d want 0", sym_count); end
    random_cw_a(1); exp = model_a();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); in_valid = 1'b1; in_sym = 3'(cw_q[i]);
    end
    @(negedge clk); in_valid = 1'b0; #1;
    vectors++; if ({syn_valid, syndromes, err_flag} !== {1'b1, exp, 1'b1}) begin errors++;
      $display("FAIL abort_result: got %b/%o/%b want 1/%o/1", syn_valid, syndromes, err_flag, exp); end
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0; #1;
    vectors++; if ({syn_valid, syndromes} !== {1'b1, exp}) begin errors++;
      $display("FAIL abort_hold: got %b/%o want 1/%o", syn_valid, syndromes, exp); end
    syn_ready = 1'b1;
    @(negedge clk); syn_ready = 1'b0;
  endtask

  task automatic test_async_reset();
    logic [5:0] exp;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); in_valid = 1'b1; in_sym = 3'($urandom_range(7, 1));
    end
    @(negedge clk); in_valid = 1'b0; #2 reset = 1'b0; #1;
    vectors++; if (sym_count !== 3'd0) begin errors++;
      $display("FAIL areset_mid_count: got %0d want 0", sym_count); end
    @(negedge clk); reset = 1'b1;
    random_cw_a(1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); in_valid = 1'b1; in_sym = 3'(cw_q[i]);
    end
    @(negedge clk); in_valid = 1'b0; #2 reset = 1'b0; #1;
    vectors++; if ({in_ready, syn_valid, err_flag, syndromes} !== {3'b100, 6'd0}) begin errors++;
      $display("FAIL areset_hold: got %b want 100000000", {in_ready, syn_valid, err_flag, syndromes}); end
    @(negedge clk); reset = 1'b1;
    random_cw_a(1); exp = model_a();
    for (int i = 0; i < 7; i++) begin
      @(negedge clk); in_valid = 1'b1; in_sym = 3'(cw_q[i]);
    end
    @(negedge clk); in_valid = 1'b0; #1;
    vectors++; if ({syn_valid, syndromes, err_flag} !== {1'b1, exp, 1'b1}) begin errors++;
      $display("FAIL areset_after: got %b/%o/%b want 1/%o/1", syn_valid, syndromes, err_flag, exp); end
    syn_ready = 1'b1;
    @(negedge clk); syn_ready = 1'b0;
  endtask

  task automatic test_m4();
    logic [15:0] exp;
    for (int k = 0; k < 6; k++) begin
      cw_q.delete();
      for (int i = 0; i < 15; i++) cw_q.push_back(k == 5 ? int'($urandom_range(15)) : 0);
      if (k < 5) cw_q[$urandom_range(14)] = int'($urandom_range(15, 1));
      exp = model_b();
      for (int i = 0; i < 15; i++) begin
        @(negedge clk); b_in_valid = 1'b1; b_in_sym = 4'(cw_q[i]);
      end
      @(negedge clk); b_in_valid = 1'b0; #1;
      vectors++; if ({b_syn_valid, b_syndromes} !== {1'b1, exp}) begin errors++;
        $display("FAIL m4_syn%0d: got %b/%h want 1/%h", k, b_syn_valid, b_syndromes, exp); end
      vectors++; if (b_err_flag !== (exp != 16'd0)) begin errors++;
        $display("FAIL m4_err%0d: got %b want %b", k, b_err_flag, exp != 16'd0); end
      b_syn_ready = 1'b1;
      @(negedge clk); b_syn_ready = 1'b0;
    end
  endtask

  initial begin
    reset = 1'b0; abort = 1'b0; in_valid = 1'b0; syn_ready = 1'b0; in_sym = 3'd0;
    b_abort = 1'b0; b_in_valid = 1'b0; b_syn_ready = 1'b0; b_in_sym = 4'd0;
    test_reset();
    test_patterns();
    test_back_to_back();
    test_gaps_abort();
    test_async_reset();
    test_m4();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/rs_syndrome_engine.md
Name: rs_syndrome_engine

Overview:
Streaming Reed-Solomon syndrome generator over GF(2^M). It accepts one received symbol per cycle through a valid/ready handshake and accumulates NSYN syndromes in parallel by Horner's rule. When the codeword is complete, it presents the packed syndromes plus an error flag on a valid/ready output. This is the parametrised successor of the fixed GF(8), two-syndrome, whole-word calculator. It sits at the front of the decoder and feeds error-locator and magnitude logic.

Parameters:
M, 3, symbol width in bits (GF(2^M)), legal 3..8
N, 7, symbols per codeword, 2..2^M-1
NSYN, 2, number of syndromes (2t), 1..N-1
FCR, 1, first consecutive root exponent; syndrome j evaluates at alpha^(FCR+j)
PRIM_POLY, 11, primitive polynomial incl. x^M term (x^3+x+1 for M=3)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset
abort  in  1  synchronous: discard partial codeword
in_valid  in  1  in_sym valid
in_ready  out  1  engine can accept in_sym
in_sym  in  M  received symbol, polynomial basis, highest-degree coefficient first
syn_valid  out  1  syndromes available
syn_ready  in  1  consumer accepts syndromes
syndromes  out  NSYN*M  S_j at bits [j*M +: M]
err_flag  out  1  OR of all S_j != 0, valid with syn_valid
sym_count  out  clog2(N+1)  symbols accepted in current codeword (debug)

Behaviour:
- Reset (reset=0, async): state=ACCUM, accumulators=0, sym_count=0, syn_valid=0, syndromes=0, err_flag=0, in_ready=1.
- Arithmetic: all GF(2^M). Add is bitwise XOR. Constant multiply by alpha^k is a fixed XOR network derived from PRIM_POLY. Exponents are reduced mod 2^M-1. No integer add/modulo on symbol values.
- Accept event: in_valid & in_ready. On accept: acc_j <= acc_j*alpha^(FCR+j) XOR in_sym for all j, and sym_count += 1.
- The first symbol of a codeword loads acc_j <= in_sym. The accumulator is treated as 0, so no separate clear cycle is needed.
- State ACCUM: in_ready=1. On the accept of the Nth symbol:
  - the syndromes register takes the updated accumulator values;
  - err_flag is computed from those values;
  - syn_valid <= 1, sym_count <= 0, and the next state is HOLD.
- Latency: syn_valid is high on the cycle after the last symbol is accepted.
- State HOLD: syndromes and err_flag are held stable while syn_valid=1 and syn_ready=0.
  - in_ready = syn_ready, combinational pass-through.
  - If syn_ready=1, syn_valid drops next cycle and the state returns to ACCUM.
  - If in_valid is also 1 in that cycle, the symbol is accepted as symbol 1 of the next codeword. This gives zero-bubble back-to-back throughput of N cycles per codeword.
- abort: sym_count <= 0, and the next accepted symbol is treated as the first.
  - Any accept in the abort cycle is discarded.
  - abort does not affect a pending HOLD result (syn_valid stays until handshake).
- The in_valid=0 gaps mid-codeword freeze all state.
- Reset mid-codeword or in HOLD returns everything to reset values immediately.
- in_sym is don't-care when in_valid=0. The engine holds no X-sensitive state.

Decomposition:
- Package rs_gf_pkg holds:
  - the state enum {ACCUM, HOLD};
  - constant functions for gf_mul_alpha_pow(sym, k, M, PRIM_POLY) and the clog2 helper;
  - the default M/PRIM_POLY pair for the GF(8) code.
- One sub-module, rs_syn_cell (parameters M, EXP, PRIM_POLY), is instantiated NSYN times via generate.
  - It holds one accumulator register and its constant alpha^EXP multiplier.
  - Its inputs are load_first and acc_en.

Test Plan:
- Defaults (M=3,N=7,NSYN=2,FCR=1), alpha=2. Stream the all-zero codeword → syndromes S1=0, S2=0, err_flag=0; syn_valid is high exactly 1 cycle after the 7th accept.
- Valid codeword g(x): symbols 0,0,0,0,1,6,3 → S1=0, S2=0, err_flag=0.
- Single-error cases:
  - zeros with value 1 at the first symbol (degree 6) → S1=5, S2=7, err_flag=1;
  - value 5 at the last symbol → S1=5, S2=5;
  - value 1 at degree 1 → S1=2, S2=4.
- Backpressure:
  - hold syn_ready=0 for 5 cycles with in_valid=1 → in_ready=0 and syndromes stable;
  - then raise syn_ready with the next codeword's first symbol present → accepted that cycle; two codewords take 14 accept cycles with no bubble.
- Random in_valid gaps inside g(x) → same result as the gap-free case. Assert abort after 3 symbols, then send a full error codeword → only the post-abort codeword is reflected.
- Drive reset low asynchronously mid-codeword and mid-HOLD → outputs return to reset values without a clock edge, and the next codeword decodes correctly. Repeat single-error checks with M=4, N=15, NSYN=4, PRIM_POLY=19 against a reference model.
